// File: rtl/spi_controller_if.sv
// Request/status and SPI pin bundle for spi_controller.
// The master side issues frame requests; the slave side is the controller itself.
interface spi_controller_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic       SCLK;
  logic       COPI;
  logic       cs;

  modport master (
    output start, rw, addr, wdata,
    input  ready, done, SCLK, COPI, cs
  );

  modport slave (
    input  start, rw, addr, wdata,
    output ready, done, SCLK, COPI, cs
  );
endinterface

// File: rtl/spi_controller.sv
// Mode-0 SPI write engine: sends a 16-bit {rw, addr, wdata} frame MSB first
// with registered SCLK/COPI/cs/done; CLK_DIV clk cycles per SCLK half-period.
//
// state | meaning
// IDLE  | ready=1, waiting for start
// SETUP | cs low, SCLK low, COPI=bit 15, one half-period
// SHIFT | 16 x (SCLK high half-period, SCLK low half-period)
// GAP   | cs high, done pulse on first cycle, one half-period
module spi_controller #(
  parameter int unsigned CLK_DIV = 4
) (
  input logic             clk,
  input logic             rst_n,
  spi_controller_if.slave bus
);

  localparam int unsigned   DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shreg_q, shreg_d;
  logic          sclk_q, sclk_d;
  logic          copi_q, copi_d;
  logic          cs_q, cs_d;
  logic          done_q, done_d;

  logic accept;
  logic tick;
  logic last_bit;

  assign accept   = (state_q == IDLE) && bus.start;
  assign tick     = (div_q == DIV_LAST);
  assign last_bit = (bit_q == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (tick) state_d = SHIFT;
      SHIFT:   if (tick && !sclk_q && last_bit) state_d = GAP;
      GAP:     if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // Every state transition lands on a tick, so the wrap also restarts the count.
    div_d   = (state_q == IDLE) ? '0 : (tick ? '0 : div_q + DW'(1));
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    cs_d    = cs_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = {bus.rw, bus.addr, bus.wdata};
          copi_d  = bus.rw;
          bit_d   = 4'd15;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
        end
      end
      SETUP: begin
        if (tick) sclk_d = 1'b1;
      end
      SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            // Falling SCLK: advance COPI to the next bit, or park it low after bit 0.
            sclk_d  = 1'b0;
            copi_d  = last_bit ? 1'b0 : shreg_q[14];
            shreg_d = shreg_q << 1;
          end else if (last_bit) begin
            cs_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            bit_d  = bit_q - 4'd1;
            sclk_d = 1'b1;
          end
        end
      end
      GAP: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        copi_d = 1'b0;
      end
      default: begin
        cs_d = 1'b1;
      end
    endcase
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = done_q;
  assign bus.SCLK  = sclk_q;
  assign bus.COPI  = copi_q;
  assign bus.cs    = cs_q;

endmodule
